// File: rtl/cl_ocl_read_responder.sv
// ---------------------------------------------------------------------------
// cl_ocl_read_responder
//
// Read-side responder for the OCL AXI-Lite register window. Accepts one read
// address at a time, decodes it against the CL register map and returns the
// selected register through a registered, backpressure-safe R channel.
// Unmapped addresses complete with SLVERR and a fixed marker word.
//
// Ports:
//   clk_main_a0                 main CL clock, rising edge
//   rst_main_n_sync             synchronous active-low reset
//   arvalid / araddr / arready  AXI-Lite read address channel
//   rvalid / rdata / rresp / rready  AXI-Lite read data channel
//   hello_world_q_byte_swapped  hello-world register value (already swapped)
//   vled_q                      virtual-LED shadow value
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | arready high, waiting for a read address
// DECODE | latched address is decoded, rdata/rresp registers are loaded
// RESP   | rvalid high, holding rdata/rresp until the master takes them
// ---------------------------------------------------------------------------
module cl_ocl_read_responder #(
  parameter logic [31:0] HELLO_ADDR    = 32'h0000_0500,
  parameter logic [31:0] VLED_ADDR     = 32'h0000_0504,
  parameter logic [31:0] RDCNT_ADDR    = 32'h0000_0508,
  parameter logic [31:0] ID_ADDR       = 32'h0000_050C,
  parameter logic [31:0] ID_VALUE      = 32'hC0DE_0001,
  parameter logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF
) (
  input  logic        clk_main_a0,
  input  logic        rst_main_n_sync,
  input  logic        arvalid,
  input  logic [31:0] araddr,
  output logic        arready,
  output logic        rvalid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        rready,
  input  logic [31:0] hello_world_q_byte_swapped,
  input  logic [15:0] vled_q
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [29:0] addr_q;
  logic        arready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  rresp_q;
  logic [31:0] rd_cnt_q;

  logic        ar_hs;
  logic        r_hs;
  logic [31:0] dec_data;
  logic [1:0]  dec_resp;

  // Byte-lane bits are not part of the register decode.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^araddr[1:0];

  assign ar_hs = (state_q == IDLE) && arready_q && arvalid;
  assign r_hs  = (state_q == RESP) && rvalid_q && rready;

  always_comb begin
    dec_data = UNMAPPED_DATA;
    dec_resp = RESP_SLVERR;
    if (addr_q == HELLO_ADDR[31:2]) begin
      dec_data = hello_world_q_byte_swapped;
      dec_resp = RESP_OKAY;
    end else if (addr_q == VLED_ADDR[31:2]) begin
      dec_data = {16'h0000, vled_q};
      dec_resp = RESP_OKAY;
    end else if (addr_q == RDCNT_ADDR[31:2]) begin
      // Counter value before this read's own completion is counted.
      dec_data = rd_cnt_q;
      dec_resp = RESP_OKAY;
    end else if (addr_q == ID_ADDR[31:2]) begin
      dec_data = ID_VALUE;
      dec_resp = RESP_OKAY;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ar_hs) state_d = DECODE;
      DECODE:  state_d = RESP;
      RESP:    if (r_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // arready/rvalid are registered copies of the next state so the outputs
  // carry no combinational path from the inputs.
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      arready_q <= (state_d == IDLE);
      rvalid_q  <= (state_d == RESP);
      if (ar_hs) begin
        addr_q <= araddr[31:2];
      end
      // Inputs are sampled only here, so rdata stays stable through RESP.
      if (state_q == DECODE) begin
        rdata_q <= dec_data;
        rresp_q <= dec_resp;
      end
    end
  end

  // Completed-read counter; counts OKAY and SLVERR alike, wraps naturally.
  always_ff @(posedge clk_main_a0) begin
    if (!rst_main_n_sync) begin
      rd_cnt_q <= '0;
    end else if (r_hs) begin
      rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: doc/cl_ocl_read_responder.md
# cl_ocl_read_responder

Read-side responder for the OCL AXI-Lite register window, running on the main CL clock beside the register-write core. Accepts one read address at a time and decodes it against the CL register map. Returns the hello-world (byte-swapped), virtual-LED, read-count and ID registers with a registered, backpressure-safe read-data handshake. Unmapped addresses complete with SLVERR and a fixed marker word, so the host never hangs.

## Interface

- HELLO_ADDR, 32'h0000_0500, hello-world register address
- VLED_ADDR, 32'h0000_0504, virtual-LED register address
- RDCNT_ADDR, 32'h0000_0508, completed-read counter address
- ID_ADDR, 32'h0000_050C, ID register address
- ID_VALUE, 32'hC0DE_0001, constant returned at ID_ADDR
- UNMAPPED_DATA, 32'hDEAD_BEEF, rdata for unmapped reads

- clk_main_a0  in  1  main CL clock; all logic on rising edge
- rst_main_n_sync  in  1  reset; one clock domain, synchronous, active-low
- arvalid  in  1  read address valid
- araddr  in  32  read address
- arready  out  1  read address ready
- rvalid  out  1  read data valid
- rdata  out  32  read data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rready  in  1  read data ready
- hello_world_q_byte_swapped  in  32  byte-swapped hello-world value
- vled_q  in  16  virtual-LED shadow value

## Operation

- States: IDLE, DECODE, RESP.
  - IDLE: arready=1. On arvalid&arready, latch araddr and go to DECODE.
  - DECODE: arready=0, rvalid=0. Compare latched addr[31:2] with each *_ADDR[31:2]; addr[1:0] are ignored. Load the rdata/rresp registers. Go to RESP.
  - RESP: rvalid=1. Hold until rvalid&rready, then go to IDLE.
- Decode results:
  - HELLO_ADDR -> hello_world_q_byte_swapped, OKAY.
  - VLED_ADDR -> {16'h0000, vled_q}, OKAY.
  - RDCNT_ADDR -> current counter value, OKAY.
  - ID_ADDR -> ID_VALUE, OKAY.
  - Any other address -> UNMAPPED_DATA, SLVERR.
- Input values are sampled in DECODE only. Changes on hello_world_q_byte_swapped or vled_q during RESP do not alter rdata.
- Read counter:
  - 32-bit; increments by 1 on every R handshake, both OKAY and SLVERR.
  - Wraps 32'hFFFF_FFFF -> 0.
  - A read of RDCNT_ADDR returns the value before its own completion is counted.
- Only one read is outstanding. arvalid seen outside IDLE is ignored until arready returns; the master holds it per AXI.
- No write channel; writes are handled elsewhere.

## Timing

- Reset values: arready=0 during reset, 1 in the first cycle after reset release (IDLE). rvalid=0, rdata=0, rresp=2'b00, counter=0, state=IDLE.
- Handshakes:
  - AR handshake at edge T: DECODE in cycle T+1; rvalid=1 from cycle T+2.
  - R handshake at edge U: rvalid=0 and arready=1 in cycle U+1.
- Minimum spacing between AR handshakes with rready held high is 3 cycles.
- rdata and rresp are stable for the whole rvalid window. rvalid never drops without rready.
- arvalid with arready=0 has no effect.
- Reset mid-transaction (any state): next cycle is IDLE with all outputs at reset values. The pending read is dropped and the counter is cleared.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan

- Reset, then read 0x500 with hello_world_q_byte_swapped=32'hEFBE_ADDE and rready=1:
  - rvalid at T+2, rdata=32'hEFBE_ADDE, rresp=00.
  - arready back 1 cycle after the R handshake.
- Read 0x504 with vled_q=16'hA5A5, then read 0x50C:
  - First read returns 32'h0000_A5A5.
  - Second read returns 32'hC0DE_0001.
  - Both rresp=00.
- Read 0x600, then 0x508:
  - First read returns 32'hDEAD_BEEF, rresp=10.
  - Second read returns 32'h0000_0001 (the SLVERR read was counted).
- Backpressure: read 0x500 with rready low for 5 cycles while hello_world_q_byte_swapped changes to 32'h1234_5678:
  - rvalid and rdata hold the DECODE-sampled value.
  - arvalid held high gets no second handshake.
- Wrap and reset:
  - Force counter to 32'hFFFF_FFFF, complete one read; a read of 0x508 then returns 0.
  - Assert reset during RESP: rvalid=0 next cycle; a later read of 0x508 returns 0.
- Alignment: read 0x503 -> hello-world value with OKAY (addr[1:0] ignored).
